// File: rtl/fcp_pkg.sv
// Shared encodings for the FCP transmit scheduler.
package fcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_RSP  = 2'd1;
    localparam logic [1:0] GNT_AFC  = 2'd2;
    localparam logic [1:0] GNT_PING = 2'd3;

    localparam logic [15:0] AFC_PAYLOAD = 16'h0000;

endpackage

// File: rtl/fcp_req_latch.sv
// Pending-request latch: sticky pend bit, optional newest-wins payload buffer, overflow pulse.
module fcp_req_latch #(
    parameter int unsigned DataW = 0,
    localparam int unsigned BufW = (DataW == 0) ? 1 : DataW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic            i_clr,
    input  logic [BufW-1:0] i_data,
    output logic            o_pend,
    output logic [BufW-1:0] o_data,
    output logic            o_ovf
);

    logic r_pend;
    logic r_ovf;

    // A request arriving in the clearing cycle keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= i_req | (r_pend & ~i_clr);
            r_ovf  <= i_req & r_pend;
        end
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

    generate
        if (DataW > 0) begin : g_buf
            logic [BufW-1:0] r_buf;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_buf <= '0;
                end else if (i_req) begin
                    r_buf <= i_data;
                end
            end
            assign o_data = r_buf;
        end else begin : g_nobuf
            logic w_unused_data;
            assign w_unused_data = ^i_data;
            assign o_data        = '0;
        end
    endgenerate

endmodule

// File: rtl/fcp_tx_sched.sv
// Fixed-priority scheduler (rsp > afc > ping) feeding the FCP TX controller,
// with an enforced inter-frame gap and a tx_done timeout.
module fcp_tx_sched
    import fcp_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 40,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rsp,
    input  logic [15:0] rsp_data,
    input  logic        req_afc,
    input  logic        req_ping,
    input  logic        tx_done,
    output logic        tx_en,
    output logic        tx_type,
    output logic        tx_afc,
    output logic [15:0] tx_data,
    output logic        busy,
    output logic [1:0]  gnt_id,
    output logic        done_rsp,
    output logic        done_afc,
    output logic        done_ping,
    output logic        err_timeout,
    output logic        ovf_rsp
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic              r_tx_en, w_tx_en_d;
    logic              r_tx_type, w_tx_type_d;
    logic              r_tx_afc, w_tx_afc_d;
    logic [15:0]       r_tx_data, w_tx_data_d;
    logic [1:0]        r_gnt, w_gnt_d;
    logic [2:0]        r_done, w_done_d;
    logic              r_err, w_err_d;
    logic [2:0]        w_clr;

    logic              w_pend_rsp, w_pend_afc, w_pend_ping;
    logic [15:0]       w_rsp_buf;
    logic              w_unused_afc_data, w_unused_afc_ovf;
    logic              w_unused_ping_data, w_unused_ping_ovf;

    fcp_req_latch #(.DataW(16)) u_lat_rsp (
        .clk    (clk),
        .rst    (rst),
        .i_req  (req_rsp),
        .i_clr  (w_clr[0]),
        .i_data (rsp_data),
        .o_pend (w_pend_rsp),
        .o_data (w_rsp_buf),
        .o_ovf  (ovf_rsp)
    );

    fcp_req_latch #(.DataW(0)) u_lat_afc (
        .clk    (clk),
        .rst    (rst),
        .i_req  (req_afc),
        .i_clr  (w_clr[1]),
        .i_data (1'b0),
        .o_pend (w_pend_afc),
        .o_data (w_unused_afc_data),
        .o_ovf  (w_unused_afc_ovf)
    );

    fcp_req_latch #(.DataW(0)) u_lat_ping (
        .clk    (clk),
        .rst    (rst),
        .i_req  (req_ping),
        .i_clr  (w_clr[2]),
        .i_data (1'b0),
        .o_pend (w_pend_ping),
        .o_data (w_unused_ping_data),
        .o_ovf  (w_unused_ping_ovf)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_tx_en_d   = r_tx_en;
        w_tx_type_d = r_tx_type;
        w_tx_afc_d  = r_tx_afc;
        w_tx_data_d = r_tx_data;
        w_gnt_d     = r_gnt;
        w_done_d    = 3'b000;
        w_err_d     = 1'b0;
        w_clr       = 3'b000;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_d = '0;
                if (w_pend_rsp || w_pend_afc || w_pend_ping) begin
                    w_state_d = ST_BUSY;
                    w_tx_en_d = 1'b1;
                end
                if (w_pend_rsp) begin
                    {w_tx_type_d, w_tx_afc_d, w_tx_data_d} = {2'b10, w_rsp_buf};
                    w_gnt_d  = GNT_RSP;
                    w_clr[0] = 1'b1;
                end else if (w_pend_afc) begin
                    {w_tx_type_d, w_tx_afc_d, w_tx_data_d} = {2'b11, AFC_PAYLOAD};
                    w_gnt_d  = GNT_AFC;
                    w_clr[1] = 1'b1;
                end else if (w_pend_ping) begin
                    {w_tx_type_d, w_tx_afc_d, w_tx_data_d} = {2'b00, 16'h0000};
                    w_gnt_d  = GNT_PING;
                    w_clr[2] = 1'b1;
                end
            end
            ST_BUSY: begin
                // tx_done takes precedence over a coincident timeout.
                if (tx_done || r_cnt == TO_LAST) begin
                    w_state_d = ST_GAP;
                    w_tx_en_d = 1'b0;
                    w_cnt_d   = '0;
                    if (tx_done) begin
                        w_done_d = {r_gnt == GNT_PING, r_gnt == GNT_AFC, r_gnt == GNT_RSP};
                    end else begin
                        w_err_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
                w_tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tx_en   <= 1'b0;
            r_tx_type <= 1'b0;
            r_tx_afc  <= 1'b0;
            r_tx_data <= '0;
            r_gnt     <= GNT_NONE;
            r_done    <= 3'b000;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_tx_en   <= w_tx_en_d;
            r_tx_type <= w_tx_type_d;
            r_tx_afc  <= w_tx_afc_d;
            r_tx_data <= w_tx_data_d;
            r_gnt     <= w_gnt_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
        end
    end

    assign tx_en       = r_tx_en;
    assign tx_type     = r_tx_type;
    assign tx_afc      = r_tx_afc;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != ST_IDLE);
    assign gnt_id      = r_gnt;
    assign done_rsp    = r_done[0];
    assign done_afc    = r_done[1];
    assign done_ping   = r_done[2];
    assign err_timeout = r_err;

endmodule

// File: tb/tb_fcp_tx_sched.sv
// Directed plus randomized bench for fcp_tx_sched against a frame/gap-level reference model.
module tb_fcp_tx_sched;

    localparam int GAP = 40;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rsp = 1'b0, req_afc = 1'b0, req_ping = 1'b0, tx_done = 1'b0;
    logic [15:0] rsp_data = 16'h0;
    logic        tx_en, tx_type, tx_afc, busy;
    logic [15:0] tx_data;
    logic [1:0]  gnt_id;
    logic        done_rsp, done_afc, done_ping, err_timeout, ovf_rsp;

    fcp_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rsp     (req_rsp),
        .rsp_data    (rsp_data),
        .req_afc     (req_afc),
        .req_ping    (req_ping),
        .tx_done     (tx_done),
        .tx_en       (tx_en),
        .tx_type     (tx_type),
        .tx_afc      (tx_afc),
        .tx_data     (tx_data),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .done_rsp    (done_rsp),
        .done_afc    (done_afc),
        .done_ping   (done_ping),
        .err_timeout (err_timeout),
        .ovf_rsp     (ovf_rsp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending set, current frame age, remaining gap length.
    bit          m_pend[3];          // 0 rsp, 1 afc, 2 ping
    logic [15:0] m_buf;
    bit          m_busy, m_in_frame;
    int          m_age, m_gap_left;
    logic        m_type, m_afc, m_err, m_ovf;
    logic [15:0] m_data;
    logic [1:0]  m_gnt;
    logic [2:0]  m_done;             // {rsp, afc, ping}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  g;
        bit  req[3];
        req = '{req_rsp, req_afc, req_ping};
        if (rst) begin
            m_pend = '{0, 0, 0};
            m_buf = 0; m_busy = 0; m_in_frame = 0; m_age = 0; m_gap_left = 0;
            m_type = 0; m_afc = 0; m_data = 0; m_gnt = 0; m_done = 0; m_err = 0; m_ovf = 0;
            return;
        end
        g = -1;
        m_done = 0;
        m_err = 0;
        m_ovf = req_rsp && m_pend[0];
        if (!m_busy) begin
            for (int i = 2; i >= 0; i--) if (m_pend[i]) g = i;
            if (g >= 0) begin
                m_busy = 1; m_in_frame = 1; m_age = 0;
                m_gnt  = 2'(g + 1);
                m_type = (g != 2);
                m_afc  = (g == 1);
                m_data = (g == 0) ? m_buf : 16'h0;
            end
        end else if (m_in_frame) begin
            if (tx_done) begin
                m_done = {m_gnt == 2'd1, m_gnt == 2'd2, m_gnt == 2'd3};
                m_in_frame = 0; m_gap_left = GAP;
            end else if (m_age == TMO - 1) begin
                m_err = 1; m_in_frame = 0; m_gap_left = GAP;
            end else begin
                m_age++;
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_busy = 0;
        end
        for (int i = 0; i < 3; i++) m_pend[i] = req[i] || (m_pend[i] && g != i);
        if (req_rsp) m_buf = rsp_data;
    endtask

    task automatic tick(input logic r, input logic [15:0] d, input logic a, input logic p,
                        input logic dn, input logic rs);
        req_rsp = r; rsp_data = d; req_afc = a; req_ping = p; tx_done = dn; rst = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("outputs",
              {tx_en, tx_type, tx_afc, tx_data, busy, gnt_id,
               done_rsp, done_afc, done_ping, err_timeout, ovf_rsp},
              {m_in_frame, m_type, m_afc, m_data, m_busy, m_gnt, m_done, m_err, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic wait_launch(input string tag);
        int n = 0;
        while (!m_in_frame && n < 200) begin idle(1); n++; end
        check(tag, tx_en, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy && n < 6000) begin idle(1); n++; end
        check("drain", busy, 1'b0);
    endtask

    logic [1:0]  gnt_exp[3]  = '{2'd1, 2'd2, 2'd3};
    logic [15:0] data_exp[3] = '{16'hA55A, 16'h0000, 16'h0000};
    logic        afc_exp[3]  = '{1'b0, 1'b1, 1'b0};

    initial begin
        int n, lows;
        tick(0, 16'h0, 0, 0, 0, 1);
        tick(0, 16'h0, 0, 0, 0, 1);
        check("reset_outputs", {tx_en, tx_type, tx_afc, tx_data, busy, gnt_id, done_rsp,
              done_afc, done_ping, err_timeout, ovf_rsp}, 64'd0);
        idle(8);

        // Single ping: launch two edges after the request pulse
        tick(0, 16'h0, 0, 1, 0, 0);
        check("ping_lat1", tx_en, 1'b0);
        idle(1);
        check("ping_lat2", {tx_en, tx_type, gnt_id}, {1'b1, 1'b0, 2'd3});
        idle(30);
        tick(0, 16'h0, 0, 0, 1, 0);
        check("ping_done", {done_ping, tx_en}, 2'b10);
        n = 0;
        while (busy && n < 100) begin idle(1); n++; end
        check("gap_len", n, 40);

        // Simultaneous requests served rsp, afc, ping with full gaps
        tick(1, 16'hA55A, 1, 1, 0, 0);
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!tx_en && n < 200) begin idle(1); n++; lows++; end
            check("multi_launch", tx_en, 1'b1);
            check("multi_gnt", gnt_id, gnt_exp[k]);
            check("multi_data", {tx_afc, tx_data}, {afc_exp[k], data_exp[k]});
            if (k > 0) check("multi_lowgap", (lows >= 41), 1'b1);
            idle(10);
            tick(0, 16'h0, 0, 0, 1, 0);
            lows = 1;
        end
        drain();

        // Overflow: newest response payload wins
        tick(0, 16'h0, 0, 1, 0, 0);
        idle(3);
        tick(1, 16'h1111, 0, 0, 0, 0);
        tick(1, 16'h2222, 0, 0, 0, 0);
        check("ovf_pulse", ovf_rsp, 1'b1);
        idle(1);
        check("ovf_single", ovf_rsp, 1'b0);
        tick(0, 16'h0, 0, 0, 1, 0);
        wait_launch("ovf_launch");
        check("ovf_data", tx_data, 16'h2222);
        tick(0, 16'h0, 0, 0, 1, 0);
        drain();

        // Timeout with a ping queued behind it
        tick(0, 16'h0, 1, 0, 0, 0);
        wait_launch("tmo_launch");
        tick(0, 16'h0, 0, 1, 0, 0);
        n = 0;
        while (m_in_frame && n < 5000) begin idle(1); n++; end
        check("tmo_err", {err_timeout, tx_en, done_rsp, done_afc, done_ping}, 5'b10000);
        wait_launch("tmo_next");
        check("tmo_next_gnt", gnt_id, 2'd3);
        tick(0, 16'h0, 0, 0, 1, 0);
        drain();

        // Request on the grant edge re-arms the pend bit
        tick(0, 16'h0, 0, 1, 0, 0);
        tick(0, 16'h0, 0, 1, 0, 0);
        check("coll_first", {tx_en, gnt_id}, {1'b1, 2'd3});
        idle(5);
        tick(0, 16'h0, 0, 0, 1, 0);
        wait_launch("coll_second");
        check("coll_second_gnt", gnt_id, 2'd3);
        tick(0, 16'h0, 0, 0, 1, 0);
        drain();
        tick(0, 16'h0, 0, 0, 1, 0);
        check("done_in_idle", {busy, tx_en, done_rsp, done_afc, done_ping}, 5'b0);

        // tx_done on the expiry cycle counts as done
        tick(0, 16'h0, 1, 0, 0, 0);
        wait_launch("dtmo_launch");
        n = 0;
        while (m_age < TMO - 1 && n < 5000) begin idle(1); n++; end
        tick(0, 16'h0, 0, 0, 1, 0);
        check("done_wins", {done_afc, err_timeout}, 2'b10);
        drain();

        // Reset mid-frame
        tick(1, 16'hBEEF, 0, 1, 0, 0);
        wait_launch("rst_launch");
        idle(4);
        tick(0, 16'h0, 0, 0, 0, 1);
        check("rst_mid", {tx_en, tx_type, tx_afc, tx_data, busy, gnt_id}, 64'd0);
        idle(3);
        check("rst_nopend", busy, 1'b0);
        tick(0, 16'h0, 1, 0, 0, 0);
        idle(1);
        check("rst_afc", {tx_en, tx_afc, gnt_id}, {1'b1, 1'b1, 2'd2});
        tick(0, 16'h0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 29) == 0, 16'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 49) == 0,
                 m_in_frame ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 1499) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
